apb_master: RTL and testbench

Single-outstanding APB3 initiator that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command. It is the requester side of the peripheral bus: one instance drives PSEL/PENABLE/PADDR/PWRITE/PWDATA into a slave such as the timer block, and firmware-facing logic or test sequencers sit on its command side. An optional watchdog aborts transfers whose slave never asserts PREADY.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_mst_wdog.sv | 30 +++
 rtl/apb_master.sv | 142 ++++++++++++++
 tb/tb_apb_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, bus phase constants and the
// default bus widths used by the initiator and the slave blocks.
package apb_pkg;

  localparam int APB_ADDR_W = 2;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Bus phase as {PSEL, PENABLE}.
  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_SETUP  = 2'b10;
  localparam logic [1:0] PH_ACCESS = 2'b11;

  function automatic logic [1:0] phase_of(input apb_state_e s);
    case (s)
      ST_SETUP:  return PH_SETUP;
      ST_ACCESS: return PH_ACCESS;
      default:   return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/apb_mst_wdog.sv
// Wait-state watchdog for apb_master: counts ACCESS cycles with PREADY low
// and flags expiry once the count reaches TIMEOUT_CYC.
module apb_mst_wdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] r_cnt;

  // Saturates so a stalled slave can never wrap the count back below the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_wait && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = (r_cnt == LP_LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 initiator: command stream in, SETUP/ACCESS on the
// bus, one response out. Watchdog abort is built only with APB_MST_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state
);

  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYC must be in 1..255");
  end

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic              r_out_en;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_cmd_hs;
  logic              w_rsp_hs;
  logic              w_done;
  logic              w_abort;
  logic              w_expired;

  // Handshakes: a transfer happens on a cycle where valid & ready are both
  // high; valid never waits on ready, and payloads are held while valid is up.
  assign w_cmd_hs = cmd_valid && cmd_ready;
  assign w_rsp_hs = rsp_valid && rsp_ready;
  assign w_done   = (r_state == ST_ACCESS) && PREADY;
  assign w_abort  = (r_state == ST_ACCESS) && !PREADY && w_expired;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_cmd_hs) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_done || w_abort) w_next = ST_RESP;
      ST_RESP:   if (w_rsp_hs) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // r_out_en keeps cmd_ready low while reset is held and until the first edge after it.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state  <= ST_IDLE;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_out_en <= 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_cmd_hs) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_done) begin
      r_rdata <= r_pwrite ? '0 : PRDATA;
      r_err   <= PSLVERR;
    end else if (w_abort) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

`ifdef APB_MST_TIMEOUT_EN
  logic r_timeout;

  apb_mst_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .i_clk     (PCLK),
    .i_rst     (PRESET),
    .i_clear   (r_state == ST_SETUP),
    .i_wait    ((r_state == ST_ACCESS) && !PREADY),
    .o_expired (w_expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_timeout <= 1'b0;
    end else if (w_done || w_abort) begin
      r_timeout <= w_abort;
    end
  end

  assign rsp_timeout = r_timeout;
`else
  assign w_expired   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready         = r_out_en && (r_state == ST_IDLE);
  assign rsp_valid         = (r_state == ST_RESP);
  assign {PSEL, PENABLE}   = phase_of(r_state);
  assign PWRITE            = r_pwrite;
  assign PADDR             = r_paddr;
  assign PWDATA            = r_pwdata;
  assign rsp_rdata         = r_rdata;
  assign rsp_err           = r_err;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and random transfers against a cycle-level
// model of the expected bus phases and responses.
module tb_apb_master;

  localparam int AW  = 2;
  localparam int DW  = 32;
  localparam int TMO = 4;
`ifdef APB_MST_TIMEOUT_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic          PCLK;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected responses packed as {timeout, err, rdata}.
  logic [DW+1:0] exp_q[$];

  apb_master #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ACCESS lasts until the slave answers, unless the
  // watchdog is built and the slave stays silent past TIMEOUT_CYC cycles.
  function automatic bit model_abort(input int waits);
    return WDOG && (waits > TMO);
  endfunction

  function automatic int model_access_cycles(input int waits);
    return model_abort(waits) ? (TMO + 1) : (waits + 1);
  endfunction

  // Driver: one full transfer, starting and ending at a falling edge while idle.
  // waits = slave wait states, hold = extra RESP cycles before rsp_ready.
  task automatic run_xfer(input bit write, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int waits,
                          input logic [DW-1:0] rdata, input bit slverr,
                          input int hold);
    int            rsp_cyc;
    int            j;
    bit            abort;
    logic [DW+1:0] exp;
    abort   = model_abort(waits);
    rsp_cyc = 2 + model_access_cycles(waits);
    exp_q.push_back({abort, abort | slverr, (abort || write) ? '0 : rdata});
    exp = '0;

    check("cmd_ready_idle", 64'(cmd_ready), 64'(1'b1));
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    rsp_ready = 1'($urandom_range(0, 1));

    for (int cyc = 1; cyc <= rsp_cyc + hold; cyc++) begin
      @(negedge PCLK);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      check("cmd_ready_busy", 64'(cmd_ready), 64'(1'b0));
      check("psel", 64'(PSEL), 64'(cyc < rsp_cyc));
      check("penable", 64'(PENABLE), 64'((cyc >= 2) && (cyc < rsp_cyc)));
      check("rsp_valid", 64'(rsp_valid), 64'(cyc >= rsp_cyc));
      if (cyc < rsp_cyc) begin
        check("paddr", 64'(PADDR), 64'(addr));
        check("pwrite", 64'(PWRITE), 64'(write));
        check("pwdata", 64'(PWDATA), 64'(wdata));
      end
      j = cyc - 2;
      if (cyc == 1) begin
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
      end else if (cyc < rsp_cyc) begin
        PREADY  = (j == waits);
        PRDATA  = (j == waits) ? rdata : $urandom;
        PSLVERR = (j == waits) ? slverr : 1'b1;
        rsp_ready = 1'($urandom_range(0, 1));
      end else begin
        if (cyc == rsp_cyc) exp = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp[DW-1:0]));
        check("rsp_err", 64'(rsp_err), 64'(exp[DW]));
        check("rsp_timeout", 64'(rsp_timeout), 64'(exp[DW+1]));
        PREADY    = 1'($urandom_range(0, 1));
        PSLVERR   = 1'($urandom_range(0, 1));
        PRDATA    = $urandom;
        rsp_ready = (cyc == rsp_cyc + hold);
      end
    end

    @(negedge PCLK);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    check("rsp_valid_after", 64'(rsp_valid), 64'(1'b0));
  endtask

  // Reset asserted a few cycles into ACCESS with a silent slave.
  task automatic reset_mid(input int access_cycles);
    check("cmd_ready_pre_rst", 64'(cmd_ready), 64'(1'b1));
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 2'd2;
    cmd_wdata = 32'h5555_AAAA;
    PREADY    = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (1 + access_cycles) @(negedge PCLK);
    check("penable_before_rst", 64'(PENABLE), 64'(1'b1));
    #2 PRESET = 1'b1;
    #1;
    check("rst_psel", 64'(PSEL), 64'(1'b0));
    check("rst_penable", 64'(PENABLE), 64'(1'b0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
    @(negedge PCLK);
    check("rst_hold_cmd_ready", 64'(cmd_ready), 64'(1'b0));
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_rel_cmd_ready", 64'(cmd_ready), 64'(1'b1));
    check("rst_rel_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("rst_rel_paddr", 64'(PADDR), 64'(0));
  endtask

  initial begin
    int waits;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    #1;
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1'b0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_rsp_err", 64'(rsp_err), 64'(1'b0));
    check("reset_rsp_timeout", 64'(rsp_timeout), 64'(1'b0));
    check("reset_psel", 64'({PSEL, PENABLE}), 64'(2'b00));
    check("reset_pwrite", 64'(PWRITE), 64'(1'b0));
    check("reset_paddr", 64'(PADDR), 64'(0));
    check("reset_pwdata", 64'(PWDATA), 64'(0));
    repeat (2) @(negedge PCLK);
    check("reset_hold_cmd_ready", 64'(cmd_ready), 64'(1'b0));
    PRESET = 1'b0;
    @(negedge PCLK);

    // Directed cases
    run_xfer(1'b1, 2'd1, 32'h0000_1234, 0, 32'hFFFF_FFFF, 1'b0, 0);
    run_xfer(1'b0, 2'd3, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1);
    run_xfer(1'b1, 2'd2, 32'hCAFE_0001, 3, 32'h0, 1'b1, 2);
    run_xfer(1'b0, 2'd0, 32'h0, 3, 32'h1357_9BDF, 1'b0, 0);

    // Back-to-back with immediate response acceptance
    for (int i = 0; i < 6; i++) begin
      run_xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 0, $urandom,
               1'($urandom_range(0, 1)), 0);
    end

    // Watchdog boundary: answer exactly at the limit, one past it, far past it
    run_xfer(1'b0, 2'd1, 32'h0, TMO, 32'hA5A5_0F0F, 1'b0, 0);
    run_xfer(1'b0, 2'd2, 32'h0, TMO + 1, 32'h1111_2222, 1'b0, 1);
    run_xfer(1'b1, 2'd3, 32'h7777_8888, 9, 32'h0, 1'b1, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      waits = $urandom_range(0, 6);
      run_xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom, waits, $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    reset_mid(2);
    run_xfer(1'b0, 2'd3, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 0);

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    bad++;
    $display("FAIL sim_timeout got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
